// File: rtl/mseq_pkg.sv
// Shared types and field offsets for the moore_fsm sequencer.
// Arbitration mode is chosen by the MSEQ_RR_EN macro; see mseq_arb.sv.
package mseq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned CMD_W = 3;
  localparam int unsigned A_BIT = 2;
  localparam int unsigned B_BIT = 1;
  localparam int unsigned I_BIT = 0;

endpackage

// File: rtl/mseq_arb.sv
// Requester arbiter: combinational winner select from a start pointer.
// MSEQ_RR_EN defined: rotating pointer (round-robin); undefined: fixed priority, index 0 first.
module mseq_arb #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] win_oh_c,
  output logic [IDW-1:0]  win_idx_c,
  output logic            win_vld_c
);

  logic [IDW-1:0] ptr;

`ifdef MSEQ_RR_EN
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;

  // After granting i, the search starts at i+1 (wrapping).
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (32'(win_idx_c) == NREQ - 1) ? '0 : win_idx_c + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, adv_i};
  assign ptr       = '0;
`endif

  // First requester found scanning upward from ptr.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_vld_c = 1'b0;
    win_idx_c = '0;
    win_oh_c  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!win_vld_c && req_i[IDW'(idx)]) begin
        win_vld_c = 1'b1;
        win_idx_c = IDW'(idx);
      end
    end
    if (win_vld_c) begin
      win_oh_c[win_idx_c] = 1'b1;
    end
  end

endmodule

// File: rtl/moore_fsm_sequencer.sv
// Shares one moore_fsm among NREQ requesters: grant, hold vector HOLD cycles, capture, respond.
// Arbitration mode: MSEQ_RR_EN defined = round-robin, undefined = fixed priority.
module moore_fsm_sequencer #(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned HOLD = 2,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NREQ-1:0]                 req,
  input  logic [mseq_pkg::CMD_W*NREQ-1:0] cmd,
  output logic [NREQ-1:0]                 gnt,
  output logic                            busy,
  output logic                            done,
  output logic [IDW-1:0]                  rsp_id,
  output logic [1:0]                      rsp_q,
  output logic                            rsp_y,
  output logic                            A,
  output logic                            B,
  output logic                            I,
  input  logic                            Qa,
  input  logic                            Qb,
  input  logic                            Y
);
  import mseq_pkg::*;

  localparam int unsigned CNT_W = 4;

  if (HOLD == 0 || HOLD > 15) begin : g_bad_hold
    $error("moore_fsm_sequencer: HOLD must be in 1..15");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("moore_fsm_sequencer: NREQ must be in 2..8");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [CMD_W-1:0]   vec_q, vec_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [1:0]         rsp_st_q, rsp_st_d;
  logic               rsp_y_q, rsp_y_d;

  logic [NREQ-1:0]    win_oh_c;
  logic [IDW-1:0]     win_idx_c;
  logic               win_vld_c;
  logic               adv_c;

  mseq_arb #(.NREQ(NREQ)) u_arb (
    .clk       (CLK),
    .rst       (RST),
    .req_i     (req),
    .adv_i     (adv_c),
    .win_oh_c  (win_oh_c),
    .win_idx_c (win_idx_c),
    .win_vld_c (win_vld_c)
  );

  // Next-state and datapath loads; vector register is never cleared between transactions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    vec_d    = vec_q;
    id_d     = id_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rsp_id_d = rsp_id_q;
    rsp_st_d = rsp_st_q;
    rsp_y_d  = rsp_y_q;
    adv_c    = 1'b0;
    unique case (state_q)
      mseq_pkg::IDLE: begin
        if (win_vld_c) begin
          state_d = mseq_pkg::HOLD;
          gnt_d   = win_oh_c;
          vec_d   = cmd[32'(win_idx_c) * CMD_W +: CMD_W];
          id_d    = win_idx_c;
          cnt_d   = CNT_W'(HOLD - 1);
          busy_d  = 1'b1;
          adv_c   = 1'b1;
        end
      end
      mseq_pkg::HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_st_d = {Qa, Qb};
          rsp_y_d  = Y;
          rsp_id_d = id_q;
          done_d   = 1'b1;
          gnt_d    = '0;
          busy_d   = 1'b0;
          state_d  = mseq_pkg::IDLE;
        end
      end
      default: state_d = mseq_pkg::IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= mseq_pkg::IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      vec_q    <= '0;
      id_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rsp_id_q <= '0;
      rsp_st_q <= '0;
      rsp_y_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      vec_q    <= vec_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rsp_id_q <= rsp_id_d;
      rsp_st_q <= rsp_st_d;
      rsp_y_q  <= rsp_y_d;
    end
  end

  assign gnt    = gnt_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign rsp_id = rsp_id_q;
  assign rsp_q  = rsp_st_q;
  assign rsp_y  = rsp_y_q;
  assign A      = vec_q[A_BIT];
  assign B      = vec_q[B_BIT];
  assign I      = vec_q[I_BIT];

endmodule

// File: doc/moore_fsm_sequencer.md
# moore_fsm_sequencer

Sequencer/arbiter that shares one `moore_fsm` instance between NREQ requesters. Each requester submits a 3-bit input vector {A,B,I}. The block grants one requester at a time and drives that vector onto the FSM for HOLD clock cycles. It then captures the FSM outputs {Qa,Qb,Y} and returns them to the granted requester with a one-cycle done pulse. It sits between the requesting logic and the `moore_fsm` input/output pins.

## Interface
- NREQ, 4, number of requesters (2..8)
- HOLD, 2, cycles each vector is held on the FSM before capture (1..15; 0 is an elaboration error)
- IDW, $clog2(NREQ), requester index width (derived, not overridable)

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request, level
- cmd  in  3*NREQ  per-requester vector; slice i = cmd[3i+2:3i] = {A,B,I}
- gnt  out  NREQ  one-hot grant, high for the whole transaction
- busy  out  1  transaction in progress (state HOLD)
- done  out  1  one-cycle pulse, response valid
- rsp_id  out  IDW  index of the completed requester
- rsp_q  out  2  captured {Qa,Qb}
- rsp_y  out  1  captured Y
- A, B, I  out  1 each  registered drive to the FSM
- Qa, Qb, Y  in  1 each  FSM outputs

## Operation
- States: IDLE, HOLD.
- IDLE: if any req is high, the arbiter picks a winner w. At the edge: gnt=onehot(w); {A,B,I} <= cmd slice w; cnt <= HOLD-1; state <= HOLD; busy=1.
- HOLD with cnt!=0: cnt decrements; A/B/I and gnt are held stable.
- HOLD with cnt==0: at the edge: rsp_q <= {Qa,Qb}, rsp_y <= Y, rsp_id <= w, done <= 1, gnt <= 0, busy <= 0, state <= IDLE.
- In IDLE, done is cleared after one cycle. A/B/I keep the last vector; they never glitch back to 0 between transactions.
- cmd is sampled only on the grant edge. Later cmd changes are ignored.
- req is ignored while in HOLD. A requester drops req on its done. If req is still high, it rejoins arbitration in the next IDLE cycle.
- Arbitration is round-robin. After granting i, priority order starts at i+1 mod NREQ. The pointer resets to 0, so req[0] has highest priority first.
- Reset: gnt=0, busy=0, done=0, rsp_id=0, rsp_q=0, rsp_y=0, A=B=I=0, state=IDLE, pointer=0.
- RST during HOLD aborts the transaction: no done, all outputs return to reset values at that edge.

## Timing
- Grant edge e0: gnt, A, B, I are valid after e0.
- done is high in the cycle after edge e0+HOLD; rsp_* is valid in that same cycle. Capture samples the FSM outputs present just before edge e0+HOLD, i.e. after HOLD-1 FSM clock edges with the new inputs applied.
- One mandatory IDLE cycle separates transactions. Back-to-back throughput is one transaction per HOLD+1 cycles.
- With HOLD=2: request seen at e0, done in the cycle after e2, next grant at e3.
- rsp_* holds its value until the next capture.

## Configuration
- `MSEQ_RR_EN` defined: round-robin arbitration as above.
- `MSEQ_RR_EN` undefined: fixed priority, lowest index wins; the pointer logic is removed.
- All other behaviour is identical in both builds.

## Structure
- Package `mseq_pkg` holds:
  - state enum {IDLE, HOLD}
  - CMD_W=3
  - field offsets A_BIT=2, B_BIT=1, I_BIT=0
- Sub-module `mseq_arb` (NREQ): pure combinational winner select plus the registered pointer. Inputs: req, pointer. Outputs: one-hot winner, winner index.
- Top level holds the FSM, counter, input-vector register and capture registers.

## Test plan
- Reset: RST high 2 cycles with req=4'b1111 -> gnt=0, done=0, A=B=I=0, busy=0.
- Single request: req[2]=1, slice 2 = 3'b101, HOLD=2 -> at e0 gnt=4'b0100 and A=1, B=0, I=1. Done in the cycle after e2, with rsp_id=2 and rsp_q/rsp_y equal to the model's Qa/Qb/Y.
- Contention, `MSEQ_RR_EN` defined: req=4'b1111 held -> grant order 0,1,2,3,0, with exactly HOLD+1 cycles between grants.
- Contention, `MSEQ_RR_EN` undefined: req=4'b1011 held -> grants 0,0,0. Drop req[0] -> grants 1,1. Drop req[1] -> grants 3.
- Abort: RST at e0+1 during HOLD -> no done pulse, gnt=0 and A=B=I=0 after that edge, next grant goes to req[0].
- Sweep: requester 1 issues all 8 vectors 000..111 in sequence -> each rsp matches the golden moore_fsm model. Also check cmd changes after grant do not alter A/B/I.
